// File: rtl/usr_pkg.sv
// usr_pkg: types and constants shared by both ends of the universal shift register link.
package usr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } deser_state_e;

  // Shift-direction encodings, identical to the sender-side mux select decoding.
  localparam logic DIR_SR = 1'b0;
  localparam logic DIR_SL = 1'b1;

endpackage

// File: rtl/usr_deser_shift.sv
// usr_deser_shift: direction-controlled receive shift register and bit counter.
// last_bit flags that the sample taken on this edge is the final data bit of the word.
module usr_deser_shift
  import usr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  dir_lat,
  input  logic                  restart,
  input  logic                  ser_in,
  output logic [DATA_WIDTH-1:0] sreg,
  output logic                  last_bit
);

  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [DATA_WIDTH-1:0] r_sreg;
  logic [DATA_WIDTH-1:0] w_base;

  // A restart discards the partial word, so the new first bit shifts into a cleared register.
  assign w_base   = restart ? '0 : r_sreg;
  assign last_bit = en && !restart && (r_cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign sreg     = r_sreg;

  // Shift one sampled bit in from the latched direction and count bits of the current word.
  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      r_sreg <= '0;
      r_cnt  <= '0;
    end else if (en) begin
      if (dir_lat == DIR_SR) begin
        r_sreg <= {ser_in, w_base[DATA_WIDTH-1:1]};
      end else begin
        r_sreg <= {w_base[DATA_WIDTH-2:0], ser_in};
      end
      if (restart) begin
        r_cnt <= CNT_WIDTH'(1);
      end else if (last_bit) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/usr_deserializer.sv
// usr_deserializer: serial-to-parallel receiver with a valid/ready word output and sticky overflow.
// Optional even-parity check enabled by defining USR_DESER_PARITY_EN.
module usr_deserializer
  import usr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                  i_clk,
  input  logic                  clr,
  input  logic                  ser_in,
  input  logic                  ser_valid,
  input  logic                  dir,
  input  logic                  frame_start,
  input  logic                  out_ready,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  overflow,
  output logic                  parity_err
);

  deser_state_e          r_state;
  deser_state_e          w_state_nxt;
  logic                  r_dir_lat;
  logic                  w_restart;
  logic                  w_shift_en;
  logic                  w_dir_eff;
  logic                  w_last_bit;
  logic                  w_done;
  logic                  w_publish;
  logic [DATA_WIDTH-1:0] w_sreg;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic                  r_overflow;

  // A sample starts a new word from IDLE or whenever frame_start accompanies it.
  assign w_restart  = ser_valid && (frame_start || r_state == IDLE);
  // The parity bit is not shifted into the data register.
  assign w_shift_en = ser_valid && (frame_start || r_state != PARITY);
  assign w_dir_eff  = w_restart ? dir : r_dir_lat;
  assign w_publish  = w_done && (!r_out_valid || out_ready);

`ifdef USR_DESER_PARITY_EN
  assign w_word = w_sreg;
`else
  // The word completes on the edge sampling its last bit, so build it from the live bit.
  assign w_word = (r_dir_lat == DIR_SR) ? {ser_in, w_sreg[DATA_WIDTH-1:1]}
                                        : {w_sreg[DATA_WIDTH-2:0], ser_in};
`endif

  usr_deser_shift #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_shift (
    .i_clk   (i_clk),
    .clr     (clr),
    .en      (w_shift_en),
    .dir_lat (w_dir_eff),
    .restart (w_restart),
    .ser_in  (ser_in),
    .sreg    (w_sreg),
    .last_bit(w_last_bit)
  );

  // State register and direction latch.
  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      r_state   <= IDLE;
      r_dir_lat <= DIR_SR;
    end else begin
      r_state <= w_state_nxt;
      if (w_restart) begin
        r_dir_lat <= dir;
      end
    end
  end

  // Next-state decode and word-completion strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    if (w_restart) begin
      w_state_nxt = SHIFT;
    end else if (ser_valid) begin
      case (r_state)
        SHIFT: begin
          if (w_last_bit) begin
`ifdef USR_DESER_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = IDLE;
            w_done      = 1'b1;
`endif
          end
        end
`ifdef USR_DESER_PARITY_EN
        PARITY: begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Output register, valid/ready handshake and sticky overflow.
  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_publish) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_done && r_out_valid && !out_ready) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef USR_DESER_PARITY_EN
  logic r_parity_err;

  // Parity result is loaded together with out_data (even parity, 1 = error).
  always_ff @(posedge i_clk or negedge clr) begin
    if (!clr) begin
      r_parity_err <= 1'b0;
    end else if (w_publish) begin
      r_parity_err <= (^w_word) ^ ser_in;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_usr_deserializer.sv
// tb_usr_deserializer: scoreboard bench for usr_deserializer with a word-level reference model.
module tb_usr_deserializer;

  localparam int unsigned W = 4;
`ifdef USR_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic         i_clk = 1'b0;
  logic         clr, ser_in, ser_valid, dir, frame_start, out_ready, ovf_clr;
  logic [W-1:0] out_data;
  logic         out_valid, overflow, parity_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [W-1:0] data;
    logic         perr;
  } exp_t;

  exp_t sb[$];
  bit   m_bits[$];
  logic m_dir     = 1'b0;
  logic m_pending = 1'b0;
  logic m_ovf     = 1'b0;

  always #5 i_clk = ~i_clk;

  usr_deserializer #(.DATA_WIDTH(W), .CNT_WIDTH(3)) dut (
    .i_clk      (i_clk),
    .clr        (clr),
    .ser_in     (ser_in),
    .ser_valid  (ser_valid),
    .dir        (dir),
    .frame_start(frame_start),
    .out_ready  (out_ready),
    .ovf_clr    (ovf_clr),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .overflow   (overflow),
    .parity_err (parity_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bits are listed in arrival order; shift-right leaves the first bit at the LSB.
  function automatic logic [W-1:0] assemble(input bit b[$], input logic d);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (d == 1'b0) w[i] = b[i];
      else           w[W-1-i] = b[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    sb.delete();
    m_pending = 1'b0;
    m_ovf     = 1'b0;
  endtask

  task automatic model_edge(input logic sv, input logic b, input logic d,
                            input logic fs, input logic rdy, input logic oc);
    logic         done;
    logic         ovf_set;
    logic [W-1:0] word;
    logic         pe;
    done    = 1'b0;
    ovf_set = 1'b0;
    word    = '0;
    pe      = 1'b0;
    if (sv) begin
      if (fs || m_bits.size() == 0) begin
        m_bits.delete();
        m_dir = d;
      end
      m_bits.push_back(b);
      if (m_bits.size() == W + (PAR ? 1 : 0)) begin
        word = assemble(m_bits, m_dir);
        if (PAR) pe = (^word) ^ m_bits[W];
        done = 1'b1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_pending || rdy) begin
        sb.push_back('{word, pe});
        m_pending = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (m_pending && rdy) begin
      m_pending = 1'b0;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (oc) m_ovf = 1'b0;
  endtask

  task automatic step(input logic sv, input logic b, input logic d,
                      input logic fs, input logic rdy, input logic oc);
    ser_valid   = sv;
    ser_in      = b;
    dir         = d;
    frame_start = fs;
    out_ready   = rdy;
    ovf_clr     = oc;
    @(posedge i_clk);
    model_edge(sv, b, d, fs, rdy, oc);
    #1;
  endtask

  // v[W-1] is sent first; rdy_last applies to the edge that completes the word.
  task automatic send(input logic [W-1:0] v, input logic d, input logic rdy,
                      input logic rdy_last, input logic fs_first, input logic pbit);
    for (int i = W - 1; i >= 0; i--) begin
      step(1'b1, v[i], d, (i == W - 1) && fs_first,
           (i == 0 && !PAR) ? rdy_last : rdy, 1'b0);
    end
    if (PAR) step(1'b1, pbit, d, 1'b0, rdy_last, 1'b0);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Monitor: handshake state every cycle, word contents on each transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      check("out_valid", out_valid, m_pending);
      check("overflow", overflow, m_ovf);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", out_data);
        end else begin
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("parity_err", parity_err, e.perr);
        end
      end
    end
  end

  initial begin
    clr = 1'b0; ser_in = 1'b0; ser_valid = 1'b0; dir = 1'b0;
    frame_start = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_parity_err", parity_err, 0);
    clr = 1'b1;
    idle(1'b0);

    // Shift-right: bits 1,0,1,1 -> 4'hD
    send(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("sr_word", out_data, 4'hD);
    check("sr_valid", out_valid, 1);
    idle(1'b1);
    check("sr_valid_one_cycle", out_valid, 0);

    // Shift-left: same bits -> 4'hB
    send(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sl_word", out_data, 4'hB);
    idle(1'b1);

    // Backpressure: 4'hD then 4'h3 with out_ready low
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("bp_word_held", out_data, 4'hD);
    check("bp_overflow", overflow, 1);
    idle(1'b1);
    check("bp_drained", out_valid, 0);
    check("bp_overflow_sticky", overflow, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_clr", overflow, 0);

    // Same-edge accept and replace
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("same_edge_valid", out_valid, 1);
    check("same_edge_word", out_data, 4'h5);
    check("same_edge_ovf", overflow, 0);
    idle(1'b1);

    // Resync: two stray bits, then frame_start with 1,1,1,1 shift-left
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(4'b1111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    check("resync_word", out_data, 4'hF);
    idle(1'b1);

    // Asynchronous reset mid-word with a held word and overflow set
    send(4'b1100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    send(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    ser_valid = 1'b0;
    clr = 1'b0;
    model_reset();
    #1;
    check("arst_out_data", out_data, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_overflow", overflow, 0);
    check("arst_parity_err", parity_err, 0);
    @(posedge i_clk);
    #1;
    clr = 1'b1;
    send(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("post_rst_word", out_data, 4'hB);
    idle(1'b1);

`ifdef USR_DESER_PARITY_EN
    send(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    check("par_ok_word", out_data, 4'hD);
    check("par_ok", parity_err, 0);
    idle(1'b1);
    send(4'b1011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("par_err", parity_err, 1);
    idle(1'b1);
`endif

    // Randomised traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, 1'($urandom), 1'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
           $urandom_range(0, 19) == 0);
    end
    repeat (3) idle(1'b1);
    check("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
